// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// No logic; definitions only.
// Not applicable.
package fetch_pkg;

    // Default instruction / address width.
    localparam int FETCH_WIDTH = 16;

    // One buffered entry carries the instruction word plus its address.
    localparam int FETCH_ENTRY_W = 2 * FETCH_WIDTH;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO with flush.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = FETCH_ENTRY_W,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [W-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i  && !flush_i;

    // Storage array is data-only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives PC controls, one outstanding imem request, buffers words for decode.
// Latency: request 1 cycle after BOOT; ir_valid rises the cycle after imem_rvalid.
// Backpressure: stops requesting while buffered + outstanding reaches DEPTH; holds req/addr until gnt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_q,
    output logic             pc_rst,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] pc_d,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             ir_valid,
    output logic [WIDTH-1:0] ir_data,
    output logic [WIDTH-1:0] ir_pc,
    input  logic             ir_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             has_space;
    logic             push;
    logic             flush;
    logic             pop;

    // A granted request always has a reserved slot, so a response never overflows.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding_q};
    assign has_space = occupancy < (CNT_W+1)'(DEPTH);

    assign imem_addr = pc_q;
    assign ir_valid  = (fifo_count != '0);
    assign pop       = ir_valid && ir_ready;

    // Sequencer state and fetch bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            pend_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    // Next state and PC/imem controls; redirect outranks grant and response.
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        pend_pc_d     = pend_pc_q;
        pc_rst        = 1'b0;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_d          = '0;
        imem_req      = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        case (state_q)
            BOOT: begin
                pc_rst  = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_d    = redirect_addr;
                    flush   = 1'b1;
                end else if (has_space) begin
                    imem_req = 1'b1;
                    if (imem_gnt) begin
                        pc_inc        = 1'b1;
                        pend_pc_d     = pc_q;
                        outstanding_d = 1'b1;
                        state_d       = WAIT;
                    end
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_d    = redirect_addr;
                    flush   = 1'b1;
                    if (imem_rvalid) begin
                        // The response lands now and is simply dropped.
                        outstanding_d = 1'b0;
                        discard_d     = 1'b0;
                        state_d       = ISSUE;
                    end else begin
                        // Still in flight: mark it stale so its response is dropped later.
                        discard_d = outstanding_q;
                    end
                end else if (imem_rvalid && outstanding_q) begin
                    push          = !discard_q;
                    outstanding_d = 1'b0;
                    discard_d     = 1'b0;
                    state_d       = ISSUE;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    fetch_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_ni     (reset),
        .push_i     (push),
        .push_dat_i ({imem_rdata, pend_pc_q}),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_dat_o ({ir_data, ir_pc}),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_q;
    logic        pc_rst, pc_load, pc_inc;
    logic [15:0] pc_d;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        ir_valid;
    logic [15:0] ir_data, ir_pc;
    logic        ir_ready;

    int total = 0;
    int bad   = 0;

    // PC register model fed by the DUT controls.
    logic [15:0] pc_reg;
    always @(posedge clk) begin
        if (pc_rst)       pc_reg <= 16'h0000;
        else if (pc_load) pc_reg <= pc_d;
        else if (pc_inc)  pc_reg <= pc_reg + 16'd1;
    end
    assign pc_q = pc_reg;

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(16), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_q          (pc_q),
        .pc_rst        (pc_rst),
        .pc_load       (pc_load),
        .pc_inc        (pc_inc),
        .pc_d          (pc_d),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .ir_valid      (ir_valid),
        .ir_data       (ir_data),
        .ir_pc         (ir_pc),
        .ir_ready      (ir_ready)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    // Memory responder: grants after gnt_hold waiting cycles, answers resp_lat cycles after acceptance.
    int          gnt_hold = 0;
    int          resp_lat = 1;
    int          req_wait = 0;
    int          lat_cnt  = 0;
    bit          acc_pending = 1'b0;
    logic [15:0] acc_addr = 16'h0000;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (acc_pending) begin
                if (lat_cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(acc_addr);
                    acc_pending = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            imem_gnt = 1'b0;
            if (imem_req && !acc_pending) begin
                if (req_wait >= gnt_hold) begin
                    imem_gnt    = 1'b1;
                    req_wait    = 0;
                    acc_pending = 1'b1;
                    lat_cnt     = resp_lat;
                    acc_addr    = imem_addr;
                end else begin
                    req_wait++;
                end
            end else begin
                req_wait = 0;
            end
        end
    end

    // Decode-side logger plus control-exclusivity watch.
    logic [15:0] got_pc[$];
    logic [15:0] got_dat[$];
    int          rst_pulses = 0;
    int          excl_viol  = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (pc_rst) rst_pulses++;
                if (int'(pc_rst) + int'(pc_load) + int'(pc_inc) > 1) excl_viol++;
                if (ir_valid && ir_ready) begin
                    got_pc.push_back(ir_pc);
                    got_dat.push_back(ir_data);
                end
            end
        end
    end

    task automatic wait_inc(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (pc_inc) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #3;
        end
    endtask

    task automatic wait_pops(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (got_pc.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #3;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000; ir_ready = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        total++; if (pc_rst !== 1'b1)       begin bad++; $display("FAIL rst_pc_rst: got %b want 1", pc_rst); end
        total++; if (imem_req !== 1'b0)     begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (pc_load !== 1'b0)      begin bad++; $display("FAIL rst_load: got %b want 0", pc_load); end
        total++; if (pc_inc !== 1'b0)       begin bad++; $display("FAIL rst_inc: got %b want 0", pc_inc); end
        total++; if (pc_d !== 16'h0000)     begin bad++; $display("FAIL rst_pc_d: got %h want 0000", pc_d); end
        total++; if (ir_valid !== 1'b0)     begin bad++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
        @(negedge clk);
        reset = 1'b1; ir_ready = 1'b1;
        #3;
        total++; if (pc_rst !== 1'b1)       begin bad++; $display("FAIL boot_pc_rst: got %b want 1", pc_rst); end
        total++; if (imem_req !== 1'b0)     begin bad++; $display("FAIL boot_req: got %b want 0", imem_req); end
        @(negedge clk);
        #3;
        total++; if (pc_rst !== 1'b0)       begin bad++; $display("FAIL issue_pc_rst: got %b want 0", pc_rst); end
        total++; if (imem_req !== 1'b1)     begin bad++; $display("FAIL first_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL first_addr: got %h want 0000", imem_addr); end
    endtask

    task automatic test_basic_stream();
        bit ok;
        @(negedge clk);
        #3;
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL lat_rvalid_cycle: ir_valid got %b want 0", ir_valid); end
        @(negedge clk);
        #3;
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL lat_push_cycle: ir_valid got %b want 1", ir_valid); end
        total++; if (ir_pc !== 16'h0000) begin bad++; $display("FAIL lat_head_pc: got %h want 0000", ir_pc); end
        wait_pops(3, 40, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL stream_timeout: got %0d pops want 3", got_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got_pc[i] !== 16'(i) || got_dat[i] !== mem_word(16'(i))) begin
                    bad++; $display("FAIL stream_word%0d: got pc %h data %h want pc %h data %h",
                                    i, got_pc[i], got_dat[i], 16'(i), mem_word(16'(i)));
                end
            end
        end
        total++; if (rst_pulses !== 1) begin bad++; $display("FAIL boot_pulses: got %0d want 1", rst_pulses); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int req_hi;
        logic [15:0] head;
        @(negedge clk);
        ir_ready = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", ir_valid); end
        total++; if (16'(pc_reg - ir_pc) !== 16'd2) begin bad++; $display("FAIL bp_entries: got %0d want 2", 16'(pc_reg - ir_pc)); end
        req_hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req) req_hi++;
            @(negedge clk);
            #3;
        end
        total++; if (req_hi !== 0) begin bad++; $display("FAIL bp_req_idle: got %0d req cycles want 0", req_hi); end
        head = ir_pc;
        got_pc.delete(); got_dat.delete();
        @(negedge clk);
        ir_ready = 1'b1;
        #3;
        wait_pops(4, 40, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL bp_resume_timeout: got %0d pops want 4", got_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_pc[i] !== 16'(head + 16'(i)) || got_dat[i] !== mem_word(16'(head + 16'(i)))) begin
                    bad++; $display("FAIL bp_word%0d: got pc %h data %h want pc %h", i, got_pc[i], got_dat[i], 16'(head + 16'(i)));
                end
            end
        end
    endtask

    task automatic test_gnt_delay();
        logic [15:0] a;
        @(negedge clk);
        gnt_hold = 3;
        #3;
        for (int i = 0; i < 10 && !imem_req; i++) begin
            @(negedge clk);
            #3;
        end
        total++;
        if (!imem_req) begin
            bad++; $display("FAIL gd_req_timeout: got %b want 1", imem_req);
        end else begin
            a = imem_addr;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    #3;
                end
                total++;
                if (imem_req !== 1'b1 || imem_addr !== a) begin
                    bad++; $display("FAIL gd_hold%0d: got req %b addr %h want 1 %h", k, imem_req, imem_addr, a);
                end
                total++;
                if (pc_inc !== 1'(k == 3)) begin
                    bad++; $display("FAIL gd_inc%0d: got %b want %b", k, pc_inc, 1'(k == 3));
                end
            end
            @(negedge clk);
            gnt_hold = 0;
            #3;
            total++; if (pc_reg !== 16'(a + 16'd1)) begin bad++; $display("FAIL gd_pc_next: got %h want %h", pc_reg, 16'(a + 16'd1)); end
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        @(negedge clk);
        resp_lat = 3; ir_ready = 1'b1;
        #3;
        wait_inc(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL rw_grant_timeout: got 0 want 1"); end
        @(negedge clk);
        redirect = 1'b1; redirect_addr = 16'h0100;
        #3;
        total++; if (pc_load !== 1'b1)   begin bad++; $display("FAIL rw_load: got %b want 1", pc_load); end
        total++; if (pc_d !== 16'h0100)  begin bad++; $display("FAIL rw_pc_d: got %h want 0100", pc_d); end
        total++; if (pc_inc !== 1'b0)    begin bad++; $display("FAIL rw_inc: got %b want 0", pc_inc); end
        total++; if (imem_req !== 1'b0)  begin bad++; $display("FAIL rw_req: got %b want 0", imem_req); end
        @(negedge clk);
        redirect = 1'b0; resp_lat = 1;
        #3;
        total++; if (ir_valid !== 1'b0)  begin bad++; $display("FAIL rw_flushed: got %b want 0", ir_valid); end
        got_pc.delete(); got_dat.delete();
        wait_pops(2, 30, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rw_pop_timeout: got %0d pops want 2", got_pc.size());
        end else begin
            total++; if (got_pc[0] !== 16'h0100) begin bad++; $display("FAIL rw_first_pc: got %h want 0100", got_pc[0]); end
            total++; if (got_dat[0] !== mem_word(16'h0100)) begin bad++; $display("FAIL rw_first_dat: got %h want %h", got_dat[0], mem_word(16'h0100)); end
            total++; if (got_pc[1] !== 16'h0101) begin bad++; $display("FAIL rw_second_pc: got %h want 0101", got_pc[1]); end
        end
    endtask

    task automatic test_redirect_rvalid();
        bit ok;
        @(negedge clk);
        ir_ready = 1'b0;
        #3;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ir_valid && pc_inc) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #3;
        end
        total++; if (!ok) begin bad++; $display("FAIL rr_setup_timeout: got 0 want 1"); end
        @(negedge clk);
        redirect = 1'b1; redirect_addr = 16'h0200;
        #3;
        total++; if (pc_inc !== 1'b0)   begin bad++; $display("FAIL rr_inc: got %b want 0", pc_inc); end
        total++; if (pc_load !== 1'b1)  begin bad++; $display("FAIL rr_load: got %b want 1", pc_load); end
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL rr_one_entry: got %b want 1", ir_valid); end
        @(negedge clk);
        redirect = 1'b0; ir_ready = 1'b1;
        #3;
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rr_empty: got %b want 0", ir_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
            bad++; $display("FAIL rr_restart: got req %b addr %h want 1 0200", imem_req, imem_addr);
        end
        got_pc.delete(); got_dat.delete();
        wait_pops(1, 30, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rr_pop_timeout: got %0d pops want 1", got_pc.size());
        end else begin
            total++; if (got_pc[0] !== 16'h0200 || got_dat[0] !== mem_word(16'h0200)) begin
                bad++; $display("FAIL rr_first: got pc %h data %h want 0200 %h", got_pc[0], got_dat[0], mem_word(16'h0200));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        @(negedge clk);
        resp_lat = 4;
        #3;
        wait_inc(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_grant_timeout: got 0 want 1"); end
        p0 = rst_pulses;
        @(negedge clk);
        reset = 1'b0;
        #3;
        total++; if (pc_rst !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0 || pc_inc !== 1'b0) begin
            bad++; $display("FAIL rm_in_reset: got rst %b req %b valid %b inc %b want 1 0 0 0", pc_rst, imem_req, ir_valid, pc_inc);
        end
        @(negedge clk);
        reset = 1'b1; resp_lat = 1;
        got_pc.delete(); got_dat.delete();
        #3;
        total++; if (pc_rst !== 1'b1) begin bad++; $display("FAIL rm_boot: got %b want 1", pc_rst); end
        wait_pops(2, 30, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rm_pop_timeout: got %0d pops want 2", got_pc.size());
        end else begin
            total++; if (got_pc[0] !== 16'h0000 || got_dat[0] !== mem_word(16'h0000)) begin
                bad++; $display("FAIL rm_first: got pc %h data %h want 0000 %h", got_pc[0], got_dat[0], mem_word(16'h0000));
            end
            total++; if (got_pc[1] !== 16'h0001) begin bad++; $display("FAIL rm_second: got %h want 0001", got_pc[1]); end
        end
        total++; if (rst_pulses - p0 !== 1) begin bad++; $display("FAIL rm_pulses: got %0d want 1", rst_pulses - p0); end
    endtask

    task automatic test_exclusive();
        total++; if (excl_viol !== 0) begin bad++; $display("FAIL pc_ctrl_exclusive: got %0d overlaps want 0", excl_viol); end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_gnt_delay();
        test_redirect_wait();
        test_redirect_rvalid();
        test_reset_mid();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
